// File: rtl/c16_tap_player.sv
// c16_tap_player: buffers a C16/Plus4 TAP byte stream and replays its pulse records on CASS_IN.
// Define TAP_HALFWAVE_EN to accept version-2 (half-wave) images; otherwise they are rejected.
module c16_tap_player #(
  parameter int CLK_DIV    = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       CLK28,
  input  logic       RESET_N,
  input  logic       TAP_START,
  input  logic [7:0] TAP_DATA,
  input  logic       TAP_VALID,
  output logic       TAP_READY,
  input  logic       KEY_PLAY,
  input  logic       CASS_MTR,
  output logic       CASS_IN,
  output logic       PLAYING,
  output logic       TAP_ERR
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);
  // "C16-TAPE-RAW", padded so any 4-bit header index is in range
  localparam logic [7:0] SIG [16] = '{8'h43, 8'h31, 8'h36, 8'h2D, 8'h54, 8'h41, 8'h50, 8'h45,
                                      8'h2D, 8'h52, 8'h41, 8'h57, 8'h00, 8'h00, 8'h00, 8'h00};

  typedef enum logic [3:0] {
    IDLE, HEADER, FETCH, LONG1, LONG2, LONG3, WAVE_LO, WAVE_HI, DONE, ERR
  } state_t;

  state_t state, state_nxt;

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          play, cass, halfwave;
  logic [4:0]    hdr_idx;
  logic [31:0]   len;
  logic [23:0]   dur, unit_cnt;
  logic [PW-1:0] pre;

  logic        empty, full, push, pop, running, wave, unit_tick, phase_end;
  logic        need_byte, start_pulse, sig_bad, bad_ver, pulse_lo;
  logic [7:0]  rd_byte;
  logic [31:0] len_dec, hdr_len;
  logic [23:0] d_long, rec_d;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign TAP_READY = !full;
  assign push      = TAP_VALID && !full && !TAP_START;
  assign rd_byte   = fifo_mem[rd_ptr[AW-1:0]];
  assign running   = play && !CASS_MTR;
  assign wave      = (state == WAVE_LO) || (state == WAVE_HI);
  assign unit_tick = running && wave && (pre == PRE_LAST);
  assign phase_end = unit_tick && (unit_cnt == 24'd1);
  assign len_dec   = len - 32'd1;
  assign hdr_len   = {rd_byte, len[31:8]};
  assign d_long    = {rd_byte, dur[23:8]};
  // A zero-length long record still has to produce a pulse
  assign rec_d     = (state == LONG3) ? ((d_long == '0) ? 24'd1 : d_long)
                                      : {13'd0, rd_byte, 3'd0};
  assign pulse_lo  = !halfwave && (rec_d[23:1] != '0);
  assign sig_bad   = (hdr_idx < 5'd12) && (rd_byte != SIG[hdr_idx[3:0]]);
`ifdef TAP_HALFWAVE_EN
  assign bad_ver   = (rd_byte > 8'd2);
`else
  assign bad_ver   = (rd_byte >= 8'd2);
`endif
  assign CASS_IN   = cass;

  always_ff @(posedge CLK28) begin
    if (!RESET_N) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      HEADER: if (pop) begin
        if (sig_bad || (hdr_idx == 5'd12 && bad_ver)) state_nxt = ERR;
        else if (hdr_idx == 5'd19) state_nxt = (hdr_len == '0) ? DONE : FETCH;
      end
      FETCH: if (pop) begin
        if (rd_byte == '0) state_nxt = (len_dec == '0) ? DONE : LONG1;
        else               state_nxt = pulse_lo ? WAVE_LO : WAVE_HI;
      end
      LONG1:   if (pop) state_nxt = (len_dec == '0) ? DONE : LONG2;
      LONG2:   if (pop) state_nxt = (len_dec == '0) ? DONE : LONG3;
      LONG3:   if (pop) state_nxt = pulse_lo ? WAVE_LO : WAVE_HI;
      WAVE_LO: if (phase_end) state_nxt = WAVE_HI;
      WAVE_HI: if (phase_end) state_nxt = (len == '0) ? DONE : FETCH;
      default: ;
    endcase
    if (TAP_START) state_nxt = HEADER;
  end

  always_comb begin
    need_byte   = (state == HEADER) || (state == FETCH) || (state == LONG1) ||
                  (state == LONG2)  || (state == LONG3);
    pop         = need_byte && running && !empty && !TAP_START;
    start_pulse = pop && (((state == FETCH) && (rd_byte != '0)) || (state == LONG3));
    PLAYING     = play && (need_byte && state != HEADER || wave);
    TAP_ERR     = (state == ERR);
  end

  always_ff @(posedge CLK28) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= TAP_DATA;
  end

  always_ff @(posedge CLK28) begin
    if (!RESET_N) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      play     <= 1'b0;
      cass     <= 1'b1;
      halfwave <= 1'b0;
      hdr_idx  <= '0;
      len      <= '0;
      dur      <= '0;
      unit_cnt <= '0;
      pre      <= '0;
    end else begin
      if (KEY_PLAY) play <= !play;
      if (TAP_START) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        cass     <= 1'b1;
        halfwave <= 1'b0;
        hdr_idx  <= '0;
        len      <= '0;
        pre      <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        // Everything below is frozen while paused, so CASS_IN keeps its level
        if (unit_tick) begin
          pre      <= '0;
          unit_cnt <= unit_cnt - 24'd1;
        end else if (running && wave) begin
          pre <= pre + PW'(1);
        end
        if (pop && state == HEADER) begin
          hdr_idx <= hdr_idx + 5'd1;
`ifdef TAP_HALFWAVE_EN
          if (hdr_idx == 5'd12) halfwave <= (rd_byte == 8'd2);
`endif
          if (hdr_idx >= 5'd16) len <= hdr_len;
        end
        if (pop && state != HEADER) len <= len_dec;
        if (pop && (state == LONG1 || state == LONG2)) dur <= d_long;
        if (start_pulse) begin
          dur <= rec_d;
          pre <= '0;
          if (halfwave) begin
            cass     <= !cass;
            unit_cnt <= rec_d;
          end else if (pulse_lo) begin
            cass     <= 1'b0;
            unit_cnt <= {1'b0, rec_d[23:1]};
          end else begin
            unit_cnt <= rec_d;
          end
        end
        if (phase_end && state == WAVE_LO) begin
          cass     <= 1'b1;
          unit_cnt <= dur - {1'b0, dur[23:1]};
        end
        if (state_nxt == DONE || state_nxt == ERR) cass <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_c16_tap_player.sv
// Bench for c16_tap_player: directed and randomized TAP streams checked against a
// pulse-duration model derived from the record rules (half-wave path under TAP_HALFWAVE_EN).
module tb_c16_tap_player;
  localparam int DIV   = 4;
  localparam int DEPTH = 16;

  logic       CLK28 = 1'b0, RESET_N = 1'b0, TAP_START = 1'b0, TAP_VALID = 1'b0;
  logic       KEY_PLAY = 1'b0, CASS_MTR = 1'b0;
  logic [7:0] TAP_DATA = 8'h00;
  logic       TAP_READY, CASS_IN, PLAYING, TAP_ERR;

  int passed = 0, total = 0, fails = 0;

  logic [7:0] stream[$];
  logic [7:0] body[$];
  int recs[$];
  int exp_lo[$], exp_hi[$], exp_slack[$];
  int exp_final;
  int obs_lo[$], obs_hi[$];
  int obs_final, pause_bad, feed_bad;
  bit timed_out;

  c16_tap_player #(.CLK_DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
    .CLK28(CLK28), .RESET_N(RESET_N), .TAP_START(TAP_START), .TAP_DATA(TAP_DATA),
    .TAP_VALID(TAP_VALID), .TAP_READY(TAP_READY), .KEY_PLAY(KEY_PLAY),
    .CASS_MTR(CASS_MTR), .CASS_IN(CASS_IN), .PLAYING(PLAYING), .TAP_ERR(TAP_ERR)
  );

  always #5 CLK28 = ~CLK28;

  task automatic tick();
    @(posedge CLK28); #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input int obs, input int lo, input int hi);
    total++;
    assert (obs >= lo && obs <= hi) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic start();
    TAP_START = 1'b1; tick(); TAP_START = 1'b0;
  endtask

  task automatic key();
    KEY_PLAY = 1'b1; tick(); KEY_PLAY = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b, output bit ok);
    TAP_DATA = b; TAP_VALID = 1'b1; ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      bit r;
      r = TAP_READY;
      tick();
      if (r) begin ok = 1'b1; break; end
    end
    TAP_VALID = 1'b0;
  endtask

  // Header (signature, version, length = body size) followed by the body records
  task automatic mk(input logic [7:0] ver);
    string s;
    s = "C16-TAPE-RAW";
    stream.delete();
    for (int i = 0; i < 12; i++) stream.push_back(s[i]);
    stream.push_back(ver);
    repeat (3) stream.push_back(8'h00);
    for (int i = 0; i < 4; i++) stream.push_back(8'(body.size() >> (8 * i)));
    foreach (body[i]) stream.push_back(body[i]);
  endtask

  task automatic push_all();
    foreach (stream[i]) begin
      bit ok;
      push_byte(stream[i], ok);
      if (!ok) feed_bad++;
    end
  endtask

  // Full-wave: low D/2 units then high D-D/2 units; pulses without a low phase merge into the high run
  task automatic build_expect();
    int acc, slack;
    bit any_lo;
    acc = 0; slack = 0; any_lo = 0;
    exp_lo.delete(); exp_hi.delete(); exp_slack.delete();
    foreach (recs[i]) begin
      int lo, hi;
      lo = recs[i] / 2;
      hi = recs[i] - lo;
      if (lo > 0) begin
        if (any_lo) begin exp_hi.push_back(acc); exp_slack.push_back(slack); end
        exp_lo.push_back(lo * DIV);
        acc = hi * DIV; slack = 6; any_lo = 1;
      end else begin
        acc += hi * DIV; slack += 6;
      end
    end
    exp_final = acc;
  endtask

  task automatic run_stream(input int pause_after, input int pause_len, input int budget);
    obs_lo.delete(); obs_hi.delete();
    obs_final = 0; timed_out = 1; pause_bad = 0; feed_bad = 0;
    fork
      push_all();
      begin : mon
        int lo_run, hi_run;
        bit seen_lo, seen_play;
        lo_run = 0; hi_run = 0; seen_lo = 0; seen_play = 0;
        for (int c = 0; c < budget; c++) begin
          tick();
          if (PLAYING === 1'b1) seen_play = 1;
          else if (seen_play) begin timed_out = 0; break; end
          if (CASS_IN === 1'b0) begin
            if (hi_run > 0 && seen_lo) obs_hi.push_back(hi_run);
            hi_run = 0; lo_run++; seen_lo = 1;
          end else begin
            if (lo_run > 0) obs_lo.push_back(lo_run);
            lo_run = 0;
            if (seen_lo) hi_run++;
          end
        end
        obs_final = hi_run;
      end
      if (pause_len > 0) begin
        for (int c = 0; c < 5000 && CASS_IN !== 1'b0; c++) tick();
        repeat (pause_after) tick();
        CASS_MTR = 1'b1;
        repeat (pause_len) begin
          tick();
          if (CASS_IN !== 1'b0) pause_bad++;
        end
        CASS_MTR = 1'b0;
      end
    join
  endtask

  task automatic compare(input string tag, input int pause_len);
    int n;
    build_expect();
    if (exp_lo.size() > 0) exp_lo[0] += pause_len;
    check({tag, ".feed"}, feed_bad, 0);
    check({tag, ".timeout"}, 32'(timed_out), 0);
    check({tag, ".nlo"}, obs_lo.size(), exp_lo.size());
    n = (obs_lo.size() < exp_lo.size()) ? obs_lo.size() : exp_lo.size();
    for (int i = 0; i < n; i++) check($sformatf("%s.lo%0d", tag, i), obs_lo[i], exp_lo[i]);
    for (int i = 0; i < obs_hi.size() && i < exp_hi.size(); i++)
      check_range($sformatf("%s.hi%0d", tag, i), obs_hi[i], exp_hi[i], exp_hi[i] + exp_slack[i]);
    if (exp_lo.size() > 0) check({tag, ".final_hi"}, obs_final, exp_final);
    check({tag, ".end_cass"}, CASS_IN, 1);
    check({tag, ".end_err"}, TAP_ERR, 0);
    check({tag, ".end_ready"}, TAP_READY, 1);
  endtask

  initial begin
    repeat (3) tick();
    check("rst.cass", CASS_IN, 1);
    check("rst.playing", PLAYING, 0);
    check("rst.err", TAP_ERR, 0);
    check("rst.ready", TAP_READY, 1);
    RESET_N = 1'b1; tick();

    // FIFO fills while play is off, then drains once play is latched
    start();
    body.delete(); mk(8'd1);
    for (int i = 0; i < DEPTH; i++) begin
      bit ok;
      push_byte(stream[i], ok);
      check($sformatf("fill%0d", i), 32'(ok), 1);
    end
    check("fifo.full_ready", TAP_READY, 0);
    key();
    for (int i = DEPTH; i < 20; i++) begin
      bit ok;
      push_byte(stream[i], ok);
      check($sformatf("fill%0d", i), 32'(ok), 1);
    end
    repeat (40) tick();
    check("drain.ready", TAP_READY, 1);
    check("drain.playing", PLAYING, 0);
    check("drain.err", TAP_ERR, 0);

    // Single 0x30 record with a 100-cycle motor pause inside the low phase
    start();
    body.delete(); body.push_back(8'h30); mk(8'd1);
    recs.delete(); recs.push_back(8 * 48);
    run_stream(200, 100, 20000);
    check("pause.hold", pause_bad, 0);
    compare("pause", 100);

    // Long record, LSB first: 0x000108
    start();
    body.delete(); body.push_back(8'h00); body.push_back(8'h08); body.push_back(8'h01);
    body.push_back(8'h00); body.push_back(8'h05); mk(8'd0);
    recs.delete(); recs.push_back(264); recs.push_back(40);
    run_stream(0, 0, 20000);
    compare("long", 0);

    // Length runs out inside a long record: no pulse at all
    start();
    body.delete(); body.push_back(8'h00); body.push_back(8'h05); mk(8'd1);
    recs.delete();
    run_stream(0, 0, 2000);
    compare("partial", 0);

    for (int round = 0; round < 2; round++) begin
      int n;
      n = 6;
      body.delete(); recs.delete();
      for (int i = 0; i < n; i++) begin
        if (i == 1 || (i != n - 1 && $urandom_range(0, 3) == 0)) begin
          int v;
          v = (i == 1) ? 0 : int'($urandom_range(0, 40));
          body.push_back(8'h00); body.push_back(8'(v)); body.push_back(8'h00); body.push_back(8'h00);
          recs.push_back((v == 0) ? 1 : v);
        end else begin
          int b;
          b = int'($urandom_range(1, 24));
          body.push_back(8'(b));
          recs.push_back(b * 8);
        end
      end
      start(); mk(8'd1);
      run_stream(0, 0, 30000);
      compare($sformatf("rnd%0d", round), 0);
    end

    // Bad signature, then recovery
    start();
    body.delete(); mk(8'd1); stream[3] = 8'h58;
    push_all();
    repeat (10) tick();
    check("sig.err", TAP_ERR, 1);
    check("sig.cass", CASS_IN, 1);
    check("sig.playing", PLAYING, 0);
    start();
    check("sig.restart_err", TAP_ERR, 0);
    body.delete(); body.push_back(8'h10); mk(8'd1);
    recs.delete(); recs.push_back(128);
    run_stream(0, 0, 5000);
    compare("recover", 0);

    // Version 3 is always rejected
    start();
    body.delete(); body.push_back(8'h10); mk(8'd3);
    push_all();
    repeat (10) tick();
    check("v3.err", TAP_ERR, 1);

    // Version 2: half-wave when enabled, rejected otherwise
    start();
    body.delete(); body.push_back(8'h10); body.push_back(8'h10); mk(8'd2);
`ifdef TAP_HALFWAVE_EN
    run_stream(0, 0, 5000);
    check("v2.nlo", obs_lo.size(), 1);
    if (obs_lo.size() > 0) check("v2.lo", obs_lo[0], 128 * DIV);
    check("v2.final_hi", obs_final, 128 * DIV);
    check("v2.err", TAP_ERR, 0);
`else
    push_all();
    repeat (10) tick();
    check("v2.err", TAP_ERR, 1);
    check("v2.cass", CASS_IN, 1);
`endif

    // Reset mid-operation, then play and start in the same cycle
    RESET_N = 1'b0; tick(); RESET_N = 1'b1;
    check("mrst.err", TAP_ERR, 0);
    check("mrst.cass", CASS_IN, 1);
    check("mrst.ready", TAP_READY, 1);
    KEY_PLAY = 1'b1; TAP_START = 1'b1; tick(); KEY_PLAY = 1'b0; TAP_START = 1'b0;
    body.delete(); body.push_back(8'h10); mk(8'd1);
    recs.delete(); recs.push_back(128);
    run_stream(0, 0, 5000);
    compare("both", 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
